// File: rtl/seg_scan_if.sv
// Bundle of data/control inputs and display pins for the multiplexed
// 7-segment scan driver; the driver sits on the slave modport.
interface seg_scan_if;
    // ssd_ld is a single-cycle strobe with no back-pressure: the word on
    // ssd_data/ssd_dp is taken on every clock where ssd_ld is 1.
    logic [31:0] ssd_data;
    logic [7:0]  ssd_dp;
    logic [7:0]  ssd_blank;
    logic        ssd_ld;
    logic [7:0]  ssd_an;
    logic [6:0]  ssd_seg;
    logic        ssd_dpo;
    logic [2:0]  ssd_idx;
    logic        ssd_frame;
    logic        ssd_state;

    modport master (
        output ssd_data, ssd_dp, ssd_blank, ssd_ld,
        input  ssd_an, ssd_seg, ssd_dpo, ssd_idx, ssd_frame, ssd_state
    );

    modport slave (
        input  ssd_data, ssd_dp, ssd_blank, ssd_ld,
        output ssd_an, ssd_seg, ssd_dpo, ssd_idx, ssd_frame, ssd_state
    );
endinterface

// File: rtl/seg_scan_drv.sv
// Multiplexed 8-digit 7-segment scan driver with frame-aligned double buffer
// and per-slot dead time. Optional leading-zero blanking: define LZ_BLANK_EN.
module seg_scan_drv #(
    parameter int TICK_DIV = 100000,
    parameter int DEAD_CYC = 16,
    parameter int NDIG     = 8
) (
    input  logic       ssd_clk,
    input  logic       ssd_rst,
    seg_scan_if.slave  bus
);

    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYC);
    localparam logic [2:0]    IDX_MAX  = 3'(NDIG - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    state_e        state_q, state_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpo_q, dpo_d;
    logic          frame_q, frame_d;
    logic [31:0]   shadow_data_q, shadow_data_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic [31:0]   active_data_q, active_data_d;
    logic [7:0]    active_dp_q, active_dp_d;
    logic          pending_q, pending_d;

    logic [7:0]    lz_mask;
    logic [3:0]    nibble;
    logic          dark;
    logic          slot_end;
    logic          wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef LZ_BLANK_EN
    // Walk down from the top digit; the first nonzero nibble or lit dp ends
    // suppression for itself and everything below. Digit 0 is never masked.
    always_comb begin
        logic sup;
        sup     = 1'b1;
        lz_mask = '0;
        for (int k = 7; k >= 1; k--) begin
            if (k < NDIG) begin
                if ((active_data_q[4*k +: 4] != 4'h0) || active_dp_q[k]) begin
                    sup = 1'b0;
                end
                lz_mask[k] = sup;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign nibble   = active_data_q[{idx_q, 2'b00} +: 4];
    assign dark     = bus.ssd_blank[idx_q] | lz_mask[idx_q];
    assign slot_end = (cnt_q == CNT_MAX);
    assign wrap     = slot_end && (idx_q == IDX_MAX);

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end

        // A load on the wrap cycle still hands the old shadow to active
        // and leaves the new word pending for the next frame.
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        pending_d     = pending_q;
        if (wrap) begin
            pending_d = 1'b0;
            if (pending_q) begin
                active_data_d = shadow_data_q;
                active_dp_d   = shadow_dp_q;
            end
        end

        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (bus.ssd_ld) begin
            shadow_data_d = bus.ssd_data;
            shadow_dp_d   = bus.ssd_dp;
            pending_d     = 1'b1;
        end

        state_d = (cnt_q < DEAD_END) ? ST_BLANK : ST_DRIVE;

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dpo_d = 1'b1;
        if (state_d == ST_DRIVE) begin
            an_d = ~(8'h01 << idx_q);
            if (!dark) begin
                seg_d = hex7(nibble);
                dpo_d = ~active_dp_q[idx_q];
            end
        end

        frame_d = wrap;
    end

    always_ff @(posedge ssd_clk or posedge ssd_rst) begin
        if (ssd_rst) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            state_q       <= ST_BLANK;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dpo_q         <= 1'b1;
            frame_q       <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dpo_q         <= dpo_d;
            frame_q       <= frame_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            pending_q     <= pending_d;
        end
    end

    assign bus.ssd_an    = an_q;
    assign bus.ssd_seg   = seg_q;
    assign bus.ssd_dpo   = dpo_q;
    assign bus.ssd_idx   = idx_q;
    assign bus.ssd_frame = frame_q;
    assign bus.ssd_state = state_q;

endmodule
